// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: shared state encoding and default frame parameters
package uart_rx_frame_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_HOLD
    } state_t;
    localparam logic [7:0]  HEADER_DEF  = 8'h55;
    localparam int          MAX_LEN_DEF = 8;
    localparam logic [19:0] TIMEOUT_DEF = 20'd104166;
    localparam int          BUF_DEPTH   = 8;
endpackage

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout: inter-byte idle counter with terminal-count flag
module uart_frame_timeout #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd104166
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [19:0] cnt;
    assign tc = cnt == TIMEOUT_CYC - 20'd1;
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 20'd1;
    end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles HEADER/LEN/payload/CHK frames from a byte receiver
// and holds a checked payload until the consumer acknowledges it.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEF,
    parameter int          MAX_LEN     = MAX_LEN_DEF,
    parameter logic [19:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Rx_Done_Sig,
    input  logic [7:0] Rx_Data,
    output logic       Rx_En_Sig,
    output logic       Frame_Valid_Sig,
    output logic       Frame_Err_Sig,
    output logic [3:0] Frame_Len,
    input  logic [2:0] Rd_Addr,
    output logic [7:0] Rd_Data,
    input  logic       Frame_Ack_Sig
);
    state_t     state;
    logic [7:0] sum;
    logic [3:0] idx;
    logic [7:0] buf_q [BUF_DEPTH];
    logic       active;
    logic       tc;

    assign active  = state inside {S_LEN, S_DATA, S_CHECK};
    assign Rd_Data = buf_q[Rd_Addr];

    uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .CLK  (CLK),
        .RST_n(RST_n),
        .clr  (Rx_Done_Sig || !active),
        .en   (active),
        .tc   (tc)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state           <= S_IDLE;
            Rx_En_Sig       <= 1'b0;
            Frame_Valid_Sig <= 1'b0;
            Frame_Err_Sig   <= 1'b0;
            Frame_Len       <= '0;
            sum             <= '0;
            idx             <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                buf_q[i] <= '0;
        end else begin
            Frame_Err_Sig <= 1'b0;
            Rx_En_Sig     <= 1'b1;
            // a byte arriving on the terminal cycle takes priority over the timeout
            if (active && tc && !Rx_Done_Sig) begin
                Frame_Err_Sig <= 1'b1;
                state         <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:
                        if (Rx_Done_Sig && Rx_Data == HEADER)
                            state <= S_LEN;
                    S_LEN:
                        if (Rx_Done_Sig) begin
                            if (Rx_Data == 8'd0 || Rx_Data > 8'(MAX_LEN)) begin
                                Frame_Err_Sig <= 1'b1;
                                state         <= S_IDLE;
                            end else begin
                                Frame_Len <= Rx_Data[3:0];
                                sum       <= Rx_Data;
                                idx       <= '0;
                                state     <= S_DATA;
                            end
                        end
                    S_DATA:
                        if (Rx_Done_Sig) begin
                            buf_q[idx[2:0]] <= Rx_Data;
                            sum             <= sum + Rx_Data;
                            idx             <= idx + 4'd1;
                            if (idx + 4'd1 == Frame_Len)
                                state <= S_CHECK;
                        end
                    S_CHECK:
                        if (Rx_Done_Sig) begin
                            if (Rx_Data == sum) begin
                                Frame_Valid_Sig <= 1'b1;
                                Rx_En_Sig       <= 1'b0;
                                state           <= S_HOLD;
                            end else begin
                                Frame_Err_Sig <= 1'b1;
                                state         <= S_IDLE;
                            end
                        end
                    S_HOLD: begin
                        Rx_En_Sig <= Frame_Ack_Sig;
                        if (Frame_Ack_Sig) begin
                            Frame_Valid_Sig <= 1'b0;
                            state           <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frames checked against a
// queue-based frame parser model.
module tb_uart_rx_frame_ctrl;
    localparam int T = 40;
    localparam logic [7:0] HDR = 8'h55;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       Rx_Done_Sig = 1'b0;
    logic [7:0] Rx_Data = '0;
    logic       Rx_En_Sig;
    logic       Frame_Valid_Sig;
    logic       Frame_Err_Sig;
    logic [3:0] Frame_Len;
    logic [2:0] Rd_Addr = '0;
    logic [7:0] Rd_Data;
    logic       Frame_Ack_Sig = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         hold = 0;
    logic [7:0] mlen = 0;
    logic [7:0] mbuf [8];

    uart_rx_frame_ctrl #(.TIMEOUT_CYC(20'(T))) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .Rx_Done_Sig    (Rx_Done_Sig),
        .Rx_Data        (Rx_Data),
        .Rx_En_Sig      (Rx_En_Sig),
        .Frame_Valid_Sig(Frame_Valid_Sig),
        .Frame_Err_Sig  (Frame_Err_Sig),
        .Frame_Len      (Frame_Len),
        .Rd_Addr        (Rd_Addr),
        .Rd_Data        (Rd_Data),
        .Frame_Ack_Sig  (Frame_Ack_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame parser model: the queue holds every byte of the frame seen so far.
    function automatic bit model_byte(input logic [7:0] b);
        logic [7:0] s;
        if (hold) return 0;
        if (q.size() == 0) begin
            if (b == HDR) q.push_back(b);
            return 0;
        end
        q.push_back(b);
        if (q.size() == 2) begin
            if (b == 0 || b > 8) begin
                q.delete();
                return 1;
            end
            return 0;
        end
        if (q.size() < int'(q[1]) + 3) return 0;
        s = 0;
        for (int i = 1; i < q.size() - 1; i++) s = s + q[i];
        if (s == b) begin
            hold = 1;
            mlen = q[1];
            for (int i = 0; i < int'(mlen); i++) mbuf[i] = q[i + 2];
        end
        q.delete();
        return !hold;
    endfunction

    task automatic send(input logic [7:0] b);
        bit e;
        @(negedge CLK);
        Rx_Done_Sig = 1'b1;
        Rx_Data     = b;
        @(posedge CLK);
        #1;
        Rx_Done_Sig = 1'b0;
        e = model_byte(b);
        chk("err_pulse", 32'(Frame_Err_Sig), 32'(e));
        chk("valid", 32'(Frame_Valid_Sig), 32'(hold));
        chk("rx_en", 32'(Rx_En_Sig), 32'(!hold));
    endtask

    task automatic check_held();
        chk("held_valid", 32'(Frame_Valid_Sig), 32'(hold));
        chk("held_len", 32'(Frame_Len), 32'(mlen));
        for (int i = 0; i < int'(mlen); i++) begin
            Rd_Addr = 3'(i);
            #1;
            chk("rd_data", 32'(Rd_Data), 32'(mbuf[i]));
        end
    endtask

    task automatic ack();
        @(negedge CLK);
        Frame_Ack_Sig = 1'b1;
        @(posedge CLK);
        #1;
        Frame_Ack_Sig = 1'b0;
        hold = 0;
        chk("ack_valid", 32'(Frame_Valid_Sig), 0);
        chk("ack_rx_en", 32'(Rx_En_Sig), 1);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        q.delete();
        hold = 0;
        chk("rst_valid", 32'(Frame_Valid_Sig), 0);
        chk("rst_err", 32'(Frame_Err_Sig), 0);
        chk("rst_rx_en", 32'(Rx_En_Sig), 0);
        chk("rst_len", 32'(Frame_Len), 0);
        Rd_Addr = 3'd0;
        #1;
        chk("rst_rd_data", 32'(Rd_Data), 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_rx_en_rise", 32'(Rx_En_Sig), 1);
        chk("rst_no_err", 32'(Frame_Err_Sig), 0);
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    initial begin
        bit seen;
        logic [7:0] fr[$];
        int kind, len;
        logic [7:0] s, j;
        #1;
        chk("reset_rx_en", 32'(Rx_En_Sig), 0);
        chk("reset_valid", 32'(Frame_Valid_Sig), 0);
        chk("reset_len", 32'(Frame_Len), 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("first_rx_en", 32'(Rx_En_Sig), 1);

        send_list('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
        check_held();
        send(8'h55);
        chk("hold_ignore_len", 32'(Frame_Len), 3);
        ack();
        chk("ack_ignored_idle", 32'(Frame_Valid_Sig), 0);
        ack();

        send_list('{8'h55, 8'h02, 8'hAA, 8'hBB, 8'h00});
        send_list('{8'h55, 8'h00, 8'h55, 8'h09});
        send_list('{8'h55, 8'h01, 8'h7F, 8'h80});
        check_held();
        ack();

        send_list('{8'h55, 8'h04, 8'h01});
        seen = 0;
        for (int i = 1; i < T; i++) begin
            @(posedge CLK);
            #1;
            if (Frame_Err_Sig) seen = 1;
        end
        chk("timeout_early", 32'(seen), 0);
        @(posedge CLK);
        #1;
        chk("timeout_err", 32'(Frame_Err_Sig), 1);
        q.delete();
        @(posedge CLK);
        #1;
        chk("timeout_single", 32'(Frame_Err_Sig), 0);

        send_list('{8'h55, 8'h04, 8'h01});
        repeat (T - 1) @(posedge CLK);
        #1;
        send_list('{8'h02, 8'h03, 8'h04, 8'h0E});
        check_held();
        ack();

        send_list('{8'h00, 8'hFF, 8'h55, 8'h01, 8'h55, 8'h56});
        check_held();
        ack();

        send_list('{8'h55, 8'h03, 8'h11});
        pulse_reset();
        send_list('{8'h55, 8'h02, 8'h10, 8'h20, 8'h32});
        check_held();
        pulse_reset();
        send_list('{8'h55, 8'h01, 8'hFE, 8'hFF});
        check_held();
        ack();

        for (int f = 0; f < 30; f++) begin
            fr.delete();
            repeat ($urandom_range(0, 2)) begin
                j = 8'($urandom_range(0, 255));
                fr.push_back(j == HDR ? 8'h54 : j);
            end
            kind = $urandom_range(0, 9);
            len = kind == 0 ? 0 : kind == 1 ? $urandom_range(9, 255) : $urandom_range(1, 8);
            fr.push_back(HDR);
            fr.push_back(8'(len));
            if (len >= 1 && len <= 8) begin
                s = 8'(len);
                for (int i = 0; i < len; i++) begin
                    j = 8'($urandom_range(0, 255));
                    fr.push_back(j);
                    s = s + j;
                end
                fr.push_back(kind == 2 ? s + 8'd1 : s);
            end
            foreach (fr[i]) begin
                send(fr[i]);
                repeat ($urandom_range(0, 5)) @(posedge CLK);
            end
            if (hold) begin
                check_held();
                ack();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter HEADER, default 8'h55, first byte of every frame.
REQ-002 Parameter MAX_LEN, default 8, maximum payload bytes (range 1..8).
REQ-003 Parameter TIMEOUT_CYC, default 20'd104166, idle CLK cycles allowed between bytes inside a frame (about 2 byte times at 50 MHz / 9600 baud).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  system clock; all state changes on its rising edge.
REQ-006 RST_n  in  1  asynchronous active-low reset.
REQ-007 Rx_Done_Sig  in  1  one-cycle pulse from the byte receiver: Rx_Data is valid.
REQ-008 Rx_Data  in  8  received byte.
REQ-009 Rx_En_Sig  out  1  enable to the byte receiver.
REQ-010 Frame_Valid_Sig  out  1  a checked frame is held in the buffer.
REQ-011 Frame_Err_Sig  out  1  one-cycle pulse when a frame is discarded.
REQ-012 Frame_Len  out  4  payload length of the held frame.
REQ-013 Rd_Addr  in  3  payload buffer read index.
REQ-014 Rd_Data  out  8  buffer[Rd_Addr], combinational read.
REQ-015 Frame_Ack_Sig  in  1  consumer releases the held frame.

Function
REQ-016 Frame format: HEADER, LEN, LEN payload bytes, CHK; CHK = (LEN + sum of payload) mod 256.
REQ-017 States: IDLE, LEN, DATA, CHECK, HOLD; a byte is consumed only in the cycle Rx_Done_Sig = 1.
REQ-018 IDLE: a byte equal to HEADER -> LEN; any other byte is dropped with no error pulse.
REQ-019 LEN: LEN of 0 or greater than MAX_LEN -> Frame_Err_Sig pulse, then IDLE; otherwise store it, sum <= LEN, index <= 0, then DATA.
REQ-020 DATA: write the byte to buffer[index], add it to the 8-bit wrapping sum, and increment index; when the LENth byte is written -> CHECK.
REQ-021 CHECK: a byte equal to the sum -> HOLD, with Frame_Valid_Sig = 1 from the next cycle; a mismatch -> Frame_Err_Sig pulse, then IDLE.
REQ-022 HOLD: Frame_Valid_Sig = 1, Frame_Len = stored LEN, and the buffer is frozen; Frame_Ack_Sig = 1 -> IDLE with Frame_Valid_Sig = 0 on the next cycle.
REQ-023 Frame_Ack_Sig outside HOLD SHALL be ignored.
REQ-024 Rx_En_Sig SHALL be 1 in IDLE, LEN, DATA and CHECK, and 0 in HOLD, so no byte is received while a frame is held.
REQ-025 A Rx_Done_Sig arriving in HOLD SHALL be ignored.
REQ-026 Timeout counter: cleared on every consumed byte and in IDLE and HOLD; it increments in LEN, DATA and CHECK.
REQ-027 When the counter reaches TIMEOUT_CYC-1 -> Frame_Err_Sig pulse, then IDLE.
REQ-028 Rx_Done_Sig and a timeout in the same cycle: the byte wins and the counter clears.
REQ-029 Frame_Err_Sig SHALL be a single-cycle pulse, asserted in the cycle after the offending byte or timeout.
REQ-030 A HEADER value arriving in LEN, DATA or CHECK is treated as data, not as a resync.
REQ-031 Rd_Data for Rd_Addr >= Frame_Len is don't-care.

Reset
REQ-032 RST_n = 0 SHALL force: state IDLE, Rx_En_Sig 0, Frame_Valid_Sig 0, Frame_Err_Sig 0, Frame_Len 0, sum 0, index 0, counter 0, and buffer all 8'h00.
REQ-033 Rx_En_Sig SHALL rise to 1 on the first CLK edge after reset release.
REQ-034 Reset during any state, including HOLD, SHALL abandon the frame with no error pulse.

Structure
REQ-035 State encodings and HEADER/MAX_LEN defaults SHALL live in the shared UART include file, with one localparam set.
REQ-036 One sub-module, uart_frame_timeout (counter plus terminal-count flag), SHALL hold the timeout counter; the buffer is an inline register array.

Verification
REQ-037 Bytes 55 03 11 22 33 69 -> Frame_Valid_Sig = 1, Frame_Len = 3, Rd_Data at addresses 0..2 = 11, 22, 33, Rx_En_Sig = 0; Frame_Ack_Sig -> IDLE with Rx_En_Sig = 1.
REQ-038 Bytes 55 02 AA BB 00 -> one Frame_Err_Sig pulse, no Frame_Valid_Sig; the next good frame is accepted.
REQ-039 Bytes 55 00 and 55 09 -> one Frame_Err_Sig pulse each, state IDLE.
REQ-040 Bytes 55 04 01 then silence for TIMEOUT_CYC cycles -> Frame_Err_Sig exactly TIMEOUT_CYC cycles after the last Rx_Done_Sig; a byte on the terminal cycle cancels the timeout.
REQ-041 Bytes 00 FF 55 01 55 56 -> the leading junk is dropped silently, the payload is 55, and the frame is valid.
REQ-042 RST_n pulsed low in DATA and in HOLD -> all outputs at reset values, no Frame_Err_Sig pulse, and the following frame is received correctly.
